// File: rtl/pipelined_tree_multiplier.sv
// pipelined_tree_multiplier: 3-stage WIDTH x WIDTH multiplier (AND array, Dadda HA/FA tree, Sklansky adder).
// Define MULT_SIGNED_EN to add the in_signed port and Baugh-Wooley two's-complement products.
module pipelined_tree_multiplier #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    input  logic [TAG_W-1:0]   in_tag,
`ifdef MULT_SIGNED_EN
    input  logic               in_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    localparam int PW   = 2 * WIDTH;
    localparam int MAXH = WIDTH + 1;
    localparam int LVLS = $clog2(PW);
    localparam int NSEQ = 16;

    typedef struct packed {
        logic [PW-1:0] a;
        logic [PW-1:0] b;
    } rows_t;

    // Sklansky prefix adder: level l merges each upper half-block with the top of its lower half.
    function automatic logic [PW-1:0] prefix_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PW-1:0] g;
        logic [PW-1:0] p;
        logic [PW-1:0] gg;
        logic [PW-1:0] pp;
        logic [PW-1:0] s;
        int            j;
        g  = a & b;
        p  = a ^ b;
        gg = g;
        pp = p;
        s  = '0;
        j  = 0;
        for (int l = 0; l < LVLS; l++) begin
            for (int i = 0; i < PW; i++) begin
                if (((i >> l) & 1) == 1) begin
                    j     = ((i >> l) << l) - 1;
                    gg[i] = gg[i] | (pp[i] & gg[j]);
                    pp[i] = pp[i] & pp[j];
                end
            end
        end
        s[0] = p[0];
        for (int i = 1; i < PW; i++) begin
            s[i] = p[i] ^ gg[i-1];
        end
        return s;
    endfunction

    logic              v0_q, v1_q, v2_q;
    logic              v0_d, v1_d, v2_d;
    logic              adv2, s0_load, s1_load, s2_load;

    logic [WIDTH-1:0]  x0_q, y0_q;
    logic [TAG_W-1:0]  tag0_q, tag1_q;
`ifdef MULT_SIGNED_EN
    logic              sgn0_q;
`endif
    rows_t             rows_d;
    logic [PW-1:0]     a1_q, b1_q;
    logic [PW-1:0]     sum_d;
    logic [PW-1:0]     p2_q;
    logic [TAG_W-1:0]  tag2_q;

    assign adv2     = v2_q & out_ready;
    assign s2_load  = v1_q & (~v2_q | adv2);
    assign s1_load  = v0_q & (~v1_q | s2_load);
    assign in_ready = ~v0_q | s1_load;
    assign s0_load  = in_valid & in_ready;

    assign v0_d = s0_load | (v0_q & ~s1_load);
    assign v1_d = s1_load | (v1_q & ~s2_load);
    assign v2_d = s2_load | (v2_q & ~adv2);

    // NOTE: blocking '=' is correct here because these are combinational scratch values; every variable gets a default first so no latch is inferred.
    always_comb begin : dadda_tree
        logic [MAXH-1:0] cols [PW];
        logic [MAXH-1:0] nxt  [PW];
        int              h    [PW];
        int              nh   [PW];
        int              seq  [NSEQ];
        int              ns;
        int              d;
        int              k;
        int              rem;
        logic            pp;
        logic            sum;
        logic            cy;

        ns     = 0;
        d      = 2;
        k      = 0;
        rem    = 0;
        pp     = 1'b0;
        sum    = 1'b0;
        cy     = 1'b0;
        rows_d = '0;
        for (int c = 0; c < PW; c++) begin
            cols[c] = '0;
            nxt[c]  = '0;
            h[c]    = 0;
            nh[c]   = 0;
        end
        for (int t = 0; t < NSEQ; t++) begin
            seq[t] = 0;
        end

        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp = x0_q[i] & y0_q[j];
`ifdef MULT_SIGNED_EN
                // Baugh-Wooley: invert the MSB row and MSB column, but not their shared corner bit.
                if ((i == WIDTH - 1) != (j == WIDTH - 1)) begin
                    pp = pp ^ sgn0_q;
                end
`endif
                cols[i+j][h[i+j]] = pp;
                h[i+j]            = h[i+j] + 1;
            end
        end
`ifdef MULT_SIGNED_EN
        cols[WIDTH][h[WIDTH]] = sgn0_q;
        h[WIDTH]              = h[WIDTH] + 1;
        cols[PW-1][h[PW-1]]   = sgn0_q;
        h[PW-1]               = h[PW-1] + 1;
`endif

        // Dadda targets 2, 3, 4, 6, 9, ... below the tallest column, applied largest first.
        for (int t = 0; t < NSEQ; t++) begin
            if (d < WIDTH) begin
                seq[ns] = d;
                ns      = ns + 1;
                d       = (d * 3) / 2;
            end
        end

        for (int s = NSEQ - 1; s >= 0; s--) begin
            if (s < ns) begin
                d = seq[s];
                for (int c = 0; c < PW; c++) begin
                    nxt[c] = '0;
                    nh[c]  = 0;
                end
                for (int c = 0; c < PW; c++) begin
                    k = 0;
                    for (int it = 0; it < MAXH; it++) begin
                        rem = h[c] - k;
                        if ((rem + nh[c] > d) && (rem >= 2)) begin
                            if ((rem + nh[c] == d + 1) || (rem == 2)) begin
                                sum = cols[c][k] ^ cols[c][k+1];
                                cy  = cols[c][k] & cols[c][k+1];
                                k   = k + 2;
                            end else begin
                                sum = cols[c][k] ^ cols[c][k+1] ^ cols[c][k+2];
                                cy  = (cols[c][k] & cols[c][k+1]) | (cols[c][k] & cols[c][k+2])
                                    | (cols[c][k+1] & cols[c][k+2]);
                                k   = k + 3;
                            end
                            nxt[c][nh[c]] = sum;
                            nh[c]         = nh[c] + 1;
                            if (c + 1 < PW) begin
                                nxt[c+1][nh[c+1]] = cy;
                                nh[c+1]           = nh[c+1] + 1;
                            end
                        end
                    end
                    for (int b = 0; b < MAXH; b++) begin
                        if ((b >= k) && (b < h[c])) begin
                            nxt[c][nh[c]] = cols[c][b];
                            nh[c]         = nh[c] + 1;
                        end
                    end
                end
                cols = nxt;
                h    = nh;
            end
        end

        for (int c = 0; c < PW; c++) begin
            rows_d.a[c] = (h[c] > 0) ? cols[c][0] : 1'b0;
            rows_d.b[c] = (h[c] > 1) ? cols[c][1] : 1'b0;
        end
    end

    assign sum_d = prefix_add(a1_q, b1_q);

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q   <= 1'b0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            p2_q   <= '0;
            tag2_q <= '0;
        end else begin
            v0_q <= v0_d;
            v1_q <= v1_d;
            v2_q <= v2_d;
            if (s2_load) begin
                p2_q   <= sum_d;
                tag2_q <= tag1_q;
            end
        end
    end

    // NOTE: internal data registers are deliberately not reset; their valid flag qualifies them.
    always_ff @(posedge clk) begin
        if (s0_load) begin
            x0_q   <= in_x;
            y0_q   <= in_y;
            tag0_q <= in_tag;
`ifdef MULT_SIGNED_EN
            sgn0_q <= in_signed;
`endif
        end
        if (s1_load) begin
            a1_q   <= rows_d.a;
            b1_q   <= rows_d.b;
            tag1_q <= tag0_q;
        end
    end

    assign out_valid = v2_q;
    assign out_p     = p2_q;
    assign out_tag   = tag2_q;
    assign busy      = v0_q | v1_q | v2_q;

endmodule

// File: tb/tb_pipelined_tree_multiplier.sv
// Directed testbench for pipelined_tree_multiplier (WIDTH=8); define MULT_SIGNED_EN to also exercise signed mode.
`timescale 1ns/1ps
module tb_pipelined_tree_multiplier;

    localparam int WIDTH = 8;
    localparam int TAG_W = 4;
    localparam int PW    = 2 * WIDTH;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_x      = '0;
    logic [WIDTH-1:0] in_y      = '0;
    logic [TAG_W-1:0] in_tag    = '0;
`ifdef MULT_SIGNED_EN
    logic             in_signed = 1'b0;
`endif
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [PW-1:0]    out_p;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipelined_tree_multiplier #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_tag    (in_tag),
`ifdef MULT_SIGNED_EN
        .in_signed (in_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (out_p !== 16'h0000) begin errors++; $display("FAIL reset_out_p: got %h want 0000", out_p); end
        checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_max();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_x      = 8'hFF;
        in_y      = 8'hFF;
        in_tag    = 4'h5;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL max_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL max_lat1_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL max_busy: got %b want 1", busy); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL max_lat2_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL max_in_ready_mid: got %b want 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL max_lat3_valid: got %b want 1", out_valid); end
        checks++; if (out_p !== 16'hFE01) begin errors++; $display("FAIL max_product: got %h want fe01", out_p); end
        checks++; if (out_tag !== 4'h5) begin errors++; $display("FAIL max_tag: got %h want 5", out_tag); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL max_drain_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]       xs [4];
        logic [7:0]       ys [4];
        logic [15:0]      ep [4];
        logic [TAG_W-1:0] tg [4];
        int               n;
        int               first;
        int               last;
        xs = '{8'd0, 8'd1, 8'd13, 8'd200};
        ys = '{8'd77, 8'd1, 8'd11, 8'd3};
        ep = '{16'd0, 16'd1, 16'd143, 16'd600};
        tg = '{4'h3, 4'h7, 4'h9, 4'hC};
        n = 0;
        first = -1;
        last = -1;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k < 4) begin
                in_valid = 1'b1;
                in_x     = xs[k];
                in_y     = ys[k];
                in_tag   = tg[k];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (k < 4) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", k, in_ready); end
            end
            if (out_valid === 1'b1) begin
                if (n < 4) begin
                    checks++; if (out_p !== ep[n]) begin errors++; $display("FAIL b2b_product[%0d]: got %0d want %0d", n, out_p, ep[n]); end
                    checks++; if (out_tag !== tg[n]) begin errors++; $display("FAIL b2b_tag[%0d]: got %h want %h", n, out_tag, tg[n]); end
                end else begin
                    checks++; errors++; $display("FAIL b2b_extra_result: got %0d want none", out_p);
                end
                if (first < 0) first = k;
                last = k;
                n++;
            end
            tick();
        end
        checks++; if (n != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", n); end
        checks++; if (first != 3) begin errors++; $display("FAIL b2b_first_cycle: got %0d want 3", first); end
        checks++; if (last - first != 3) begin errors++; $display("FAIL b2b_consecutive: got span %0d want 3", last - first); end
    endtask

    task automatic test_backpressure();
        logic [7:0]       bx [5];
        logic [7:0]       by [5];
        logic [15:0]      bp [5];
        logic [TAG_W-1:0] bt [5];
        int               bi;
        int               ri;
        bx = '{8'd3, 8'd5, 8'd7, 8'd9, 8'd11};
        by = '{8'd4, 8'd6, 8'd8, 8'd10, 8'd12};
        bp = '{16'd12, 16'd30, 16'd56, 16'd90, 16'd132};
        bt = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        bi = 0;
        ri = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = (bi < 5);
            if (bi < 5) begin
                in_x   = bx[bi];
                in_y   = by[bi];
                in_tag = bt[bi];
            end
            #1;
            checks++; if (in_ready !== (k < 3)) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want %b", k, in_ready, (k < 3)); end
            if (k >= 3) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid[%0d]: got %b want 1", k, out_valid); end
                checks++; if (out_p !== 16'd12) begin errors++; $display("FAIL bp_stall_hold[%0d]: got %0d want 12", k, out_p); end
            end
            if (in_valid && in_ready) bi++;
            tick();
        end
        checks++; if (bi != 3) begin errors++; $display("FAIL bp_accepted: got %0d want 3", bi); end
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_valid = (bi < 5);
            if (bi < 5) begin
                in_x   = bx[bi];
                in_y   = by[bi];
                in_tag = bt[bi];
            end
            #1;
            if (out_valid === 1'b1) begin
                if (ri < 5) begin
                    checks++; if (out_p !== bp[ri]) begin errors++; $display("FAIL bp_product[%0d]: got %0d want %0d", ri, out_p, bp[ri]); end
                    checks++; if (out_tag !== bt[ri]) begin errors++; $display("FAIL bp_tag[%0d]: got %h want %h", ri, out_tag, bt[ri]); end
                end else begin
                    checks++; errors++; $display("FAIL bp_duplicate: got %0d want none", out_p);
                end
                ri++;
            end
            if (in_valid && in_ready) bi++;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (ri != 5) begin errors++; $display("FAIL bp_result_count: got %0d want 5", ri); end
        checks++; if (bi != 5) begin errors++; $display("FAIL bp_beat_count: got %0d want 5", bi); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_x      = 8'd2;
        in_y      = 8'd2;
        in_tag    = 4'hA;
        tick();
        in_x      = 8'd4;
        in_y      = 8'd4;
        in_tag    = 4'hB;
        tick();
        in_valid  = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before: got %b want 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_async: got %b want 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_async: got %b want 0", out_valid); end
        checks++; if (out_p !== 16'h0000) begin errors++; $display("FAIL rst_out_p_async: got %h want 0000", out_p); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_async: got %b want 1", in_ready); end
        tick();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale[%0d]: got valid=%b p=%0d want 0", k, out_valid, out_p); end
        end
        in_valid = 1'b1;
        in_x     = 8'd3;
        in_y     = 8'd5;
        in_tag   = 4'h6;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_post_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_post_valid: got %b want 1", out_valid); end
        checks++; if (out_p !== 16'd15) begin errors++; $display("FAIL rst_post_product: got %0d want 15", out_p); end
        checks++; if (out_tag !== 4'h6) begin errors++; $display("FAIL rst_post_tag: got %h want 6", out_tag); end
        tick();
    endtask

    task automatic test_random();
        logic [15:0]      exp_p [$];
        logic [TAG_W-1:0] exp_t [$];
        logic [15:0]      ep;
        logic [TAG_W-1:0] et;
        int               sent;
        int               rcvd;
        sent = 0;
        rcvd = 0;
        for (int k = 0; k < 2000; k++) begin
            if (sent < 300 || rcvd < 300) begin
                in_valid  = (sent < 300) && ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                in_x      = 8'($urandom_range(0, 255));
                in_y      = 8'($urandom_range(0, 255));
                in_tag    = 4'($urandom_range(0, 15));
                #1;
                if (out_valid && out_ready) begin
                    if (exp_p.size() > 0) begin
                        ep = exp_p.pop_front();
                        et = exp_t.pop_front();
                        checks++; if (out_p !== ep) begin errors++; $display("FAIL rand_product[%0d]: got %0d want %0d", rcvd, out_p, ep); end
                        checks++; if (out_tag !== et) begin errors++; $display("FAIL rand_tag[%0d]: got %h want %h", rcvd, out_tag, et); end
                    end else begin
                        checks++; errors++; $display("FAIL rand_unexpected: got %0d want none", out_p);
                    end
                    rcvd++;
                end
                if (in_valid && in_ready) begin
                    exp_p.push_back(16'(in_x) * 16'(in_y));
                    exp_t.push_back(in_tag);
                    sent++;
                end
                tick();
            end
        end
        in_valid = 1'b0;
        checks++; if (rcvd != 300) begin errors++; $display("FAIL rand_count: got %0d want 300", rcvd); end
        checks++; if (exp_p.size() != 0) begin errors++; $display("FAIL rand_leftover: got %0d want 0", exp_p.size()); end
    endtask

`ifdef MULT_SIGNED_EN
    task automatic test_signed();
        logic [7:0]  xs [3];
        logic [7:0]  ys [3];
        logic        sg [3];
        logic [15:0] ep [3];
        int          n;
        xs = '{8'h80, 8'hFF, 8'hFF};
        ys = '{8'h80, 8'h02, 8'h02};
        sg = '{1'b1, 1'b1, 1'b0};
        ep = '{16'h4000, 16'hFFFE, 16'h01FE};
        n = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k < 3) begin
                in_valid  = 1'b1;
                in_x      = xs[k];
                in_y      = ys[k];
                in_signed = sg[k];
                in_tag    = 4'(k);
            end else begin
                in_valid  = 1'b0;
                in_signed = 1'b0;
            end
            #1;
            if (out_valid === 1'b1) begin
                if (n < 3) begin
                    checks++; if (out_p !== ep[n]) begin errors++; $display("FAIL signed_product[%0d]: got %h want %h", n, out_p, ep[n]); end
                end else begin
                    checks++; errors++; $display("FAIL signed_extra: got %h want none", out_p);
                end
                n++;
            end
            tick();
        end
        checks++; if (n != 3) begin errors++; $display("FAIL signed_count: got %0d want 3", n); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_max();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random();
`ifdef MULT_SIGNED_EN
        test_signed();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
